// File: rtl/wrr_burst_arb_pkg.sv
// -----------------------------------------------------------------------------
// wrr_arb_pkg
// Shared types and helpers for the weighted round-robin burst arbiter:
//   state_t          FSM state encoding (IDLE, GRANT)
//   WW_DEFAULT       default weight-slice width
//   id_width()       width of a requester index for N requesters
//   weight_lsb()     LSB of requester idx's slice in the packed weight bus
// -----------------------------------------------------------------------------
package wrr_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int WW_DEFAULT = 4;

   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int weight_lsb(input int idx, input int ww);
      return idx * ww;
   endfunction

endpackage

// File: rtl/wrr_burst_arb_if.sv
// -----------------------------------------------------------------------------
// wrr_burst_arb_if
// Requester/resource handshake bundle for wrr_burst_arb.
//   en, req, last, weight, ready      driven by the requester side (master)
//   grant, grant_ID, grant_valid,
//   timeout                           driven by the arbiter (slave)
// -----------------------------------------------------------------------------
interface wrr_burst_arb_if #(
   parameter int N  = 4,
   parameter int WW = wrr_arb_pkg::WW_DEFAULT
);
   localparam int IW = wrr_arb_pkg::id_width(N);

   logic            en;
   logic [N-1:0]    req;
   logic            last;
   logic [N*WW-1:0] weight;
   logic            ready;
   logic [N-1:0]    grant;
   logic [IW-1:0]   grant_ID;
   logic            grant_valid;
   logic            timeout;

   modport master (
      output en, req, last, weight, ready,
      input  grant, grant_ID, grant_valid, timeout
   );

   modport slave (
      input  en, req, last, weight, ready,
      output grant, grant_ID, grant_valid, timeout
   );

endinterface

// File: rtl/wrr_burst_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-and-priority-encode. Finds the first set bit of
// (req_i & mask_i) at or above pointer_i, wrapping modulo N.
//   req_i      N   request vector
//   pointer_i  IW  highest-priority index
//   mask_i     N   candidates allowed this cycle (owner exclusion)
//   onehot_o   N   one-hot pick
//   idx_o      IW  index of pick
//   any_o      1   a candidate exists
// -----------------------------------------------------------------------------
module rr_pick
   import wrr_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = id_width(N)
)(
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] pointer_i,
   input  logic [N-1:0]  mask_i,
   output logic [N-1:0]  onehot_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   logic [N-1:0]   cand;
   logic [2*N-1:0] rot;
   int             pos;

   assign cand = req_i & mask_i;
   // Doubling the vector makes the wrap-around a plain right shift.
   assign rot  = {cand, cand} >> pointer_i;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // one unassigned, which would infer a latch.
      onehot_o = '0;
      idx_o    = '0;
      any_o    = 1'b0;
      pos      = 0;
      for (int i = 0; i < N; i++) begin
         if (!any_o && rot[i]) begin
            any_o = 1'b1;
            pos   = int'(pointer_i) + i;
            if (pos >= N) pos = pos - N;
            idx_o    = IW'(pos);
            onehot_o = N'(1) << pos;
         end
      end
   end

endmodule

// File: rtl/wrr_burst_arb.sv
// -----------------------------------------------------------------------------
// wrr_burst_arb
// Weighted round-robin burst arbiter. A grant is held for up to weight[owner]
// counted beats (weight 0 acts as 1), or until a counted beat with last, or
// until the owner drops req. Priority then rotates to owner+1, and the next
// owner is granted on the same edge when en allows it.
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   bus (slave)  en, req, last, weight, ready in; grant, grant_ID,
//                grant_valid, timeout out (all outputs registered)
// Optional build macro WRR_BURST_ARB_TIMEOUT_EN: releases an owner after
// TIMEOUT consecutive grant cycles without a counted beat and pulses timeout.
// -----------------------------------------------------------------------------
module wrr_burst_arb
   import wrr_arb_pkg::*;
#(
   parameter int N       = 4,
   parameter int WW      = 4,
   parameter int TIMEOUT = 15
)(
   input  logic           clk,
   input  logic           rst,
   wrr_burst_arb_if.slave bus
);

   localparam int IW = id_width(N);

   if (N < 2 || N > 16 || WW < 1 || TIMEOUT < 1) begin : g_param_check
      $error("wrr_burst_arb: parameter out of range");
   end

   state_t          state_q;
   logic [N-1:0]    grant_q;
   logic [IW-1:0]   id_q;
   logic [IW-1:0]   ptr_q;
   logic            valid_q;
   logic            timeout_q;
   logic [WW-1:0]   quant_q;
   logic [WW-1:0]   cnt_q;

   logic            owner_req;
   logic            beat;
   logic            to_hit;
   logic            release_w;
   logic [WW-1:0]   cnt_d;
   logic [WW-1:0]   wt_pick;
   logic [WW-1:0]   quant_d;
   logic [IW-1:0]   ptr_d;
   logic [IW-1:0]   pick_ptr;
   logic [IW-1:0]   pick_idx;
   logic [N-1:0]    pick_mask;
   logic [N-1:0]    pick_oh;
   logic            pick_any;

   // grant_q is one-hot on the owner, so this is req[grant_ID].
   assign owner_req = |(bus.req & grant_q);
   assign beat      = (state_q == GRANT) && bus.ready && owner_req;
   assign cnt_d     = cnt_q + WW'(1);
   assign ptr_d     = (id_q == IW'(N - 1)) ? '0 : id_q + IW'(1);

   assign release_w = (state_q == GRANT) &&
                      (!owner_req || (beat && (bus.last || cnt_d == quant_q)) || to_hit);

   // While granted the pick only matters on release: it starts after the
   // owner and never returns the owner itself.
   assign pick_ptr  = (state_q == GRANT) ? ptr_d : ptr_q;
   assign pick_mask = (state_q == GRANT) ? ~grant_q : '1;

   assign wt_pick   = bus.weight[weight_lsb(int'(pick_idx), WW) +: WW];
   assign quant_d   = (wt_pick == '0) ? WW'(1) : wt_pick;

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .req_i     (bus.req),
      .pointer_i (pick_ptr),
      .mask_i    (pick_mask),
      .onehot_o  (pick_oh),
      .idx_o     (pick_idx),
      .any_o     (pick_any)
   );

`ifdef WRR_BURST_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] idle_q;
   // idle_q counts prior beat-less grant cycles; this cycle makes TIMEOUT.
   assign to_hit = (state_q == GRANT) && !beat && (idle_q == TW'(TIMEOUT - 1));
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         id_q      <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         ptr_q     <= '0;
         quant_q   <= '0;
         cnt_q     <= '0;
`ifdef WRR_BURST_ARB_TIMEOUT_EN
         idle_q    <= '0;
`endif
      end else begin
         timeout_q <= 1'b0;
         if (state_q == GRANT) begin
            // Saturating count; reaching the quantum also releases.
            if (beat && cnt_q != quant_q) cnt_q <= cnt_d;
`ifdef WRR_BURST_ARB_TIMEOUT_EN
            if (beat) idle_q <= '0;
            else      idle_q <= idle_q + TW'(1);
`endif
         end
         if (state_q == IDLE || release_w) begin
            if (release_w) begin
               ptr_q     <= ptr_d;
               timeout_q <= to_hit;
            end
            if (bus.en && pick_any) begin
               state_q <= GRANT;
               grant_q <= pick_oh;
               id_q    <= pick_idx;
               valid_q <= 1'b1;
               quant_q <= quant_d;
               cnt_q   <= '0;
`ifdef WRR_BURST_ARB_TIMEOUT_EN
               idle_q  <= '0;
`endif
            end else begin
               state_q <= IDLE;
               grant_q <= '0;
               id_q    <= '0;
               valid_q <= 1'b0;
            end
         end
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_ID    = id_q;
   assign bus.grant_valid = valid_q;
   assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_wrr_burst_arb.sv
// -----------------------------------------------------------------------------
// tb_wrr_burst_arb
// Directed bench for wrr_burst_arb (N=4, WW=4, TIMEOUT=4). Inputs change 1 ns
// after a rising edge; outputs are sampled at the same point, i.e. they show
// the state registered on the edge just taken.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wrr_burst_arb;

   localparam int N  = 4;
   localparam int WW = 4;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   wrr_burst_arb_if #(.N(N), .WW(WW)) bus ();

   wrr_burst_arb #(.N(N), .WW(WW), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // {grant_valid, grant, grant_ID, timeout} for a live owner
   function automatic logic [7:0] owner_vec(input int id, input logic to);
      logic [3:0] one;
      one = 4'b0001;
      return {1'b1, one << id, 2'(id), to};
   endfunction

   function automatic logic [7:0] got_vec();
      return {bus.grant_valid, bus.grant, bus.grant_ID, bus.timeout};
   endfunction

   task automatic test_reset();
      logic [7:0] g;
      bus.en = 1'b1; bus.req = 4'b1111; bus.ready = 1'b1; bus.last = 1'b0;
      bus.weight = {4'd2, 4'd2, 4'd2, 4'd2};
      do_reset();
      g = got_vec();
      n_cmp++;
      if (g !== 8'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b required %b", g, 8'b0);
      end
      tick();
      g = got_vec();
      n_cmp++;
      if (g !== owner_vec(0, 1'b0)) begin
         n_bad++;
         $display("FAIL reset_first_grant: got %b required %b", g, owner_vec(0, 1'b0));
      end
   endtask

   task automatic test_quantum_rotation();
      int seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
      logic [7:0] g;
      bus.req = 4'b0000;
      do_reset();
      bus.en = 1'b1; bus.req = 4'b1111; bus.ready = 1'b1; bus.last = 1'b0;
      bus.weight = {4'd2, 4'd2, 4'd2, 4'd2};
      for (int k = 0; k < 9; k++) begin
         tick();
         g = got_vec();
         n_cmp++;
         if (g !== owner_vec(seq[k], 1'b0)) begin
            n_bad++;
            $display("FAIL rotation[%0d]: got %b required %b", k, g, owner_vec(seq[k], 1'b0));
         end
      end
   endtask

   task automatic test_weighting();
      int seq [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
      logic [7:0] g;
      for (int pass = 0; pass < 2; pass++) begin
         bus.req = 4'b0000;
         do_reset();
         bus.en = 1'b1; bus.req = 4'b0011; bus.ready = 1'b1; bus.last = 1'b0;
         // second pass: weight 0 on requester 1 must act as 1
         bus.weight = {4'd2, 4'd2, (pass == 0) ? 4'd1 : 4'd0, 4'd3};
         for (int k = 0; k < 8; k++) begin
            tick();
            g = got_vec();
            n_cmp++;
            if (g !== owner_vec(seq[k], 1'b0)) begin
               n_bad++;
               $display("FAIL weighting_p%0d[%0d]: got %b required %b", pass, k, g,
                        owner_vec(seq[k], 1'b0));
            end
         end
      end
   endtask

   task automatic test_early_release();
      logic [7:0] g;
      // last on first accepted beat, quantum 5
      bus.req = 4'b0000;
      do_reset();
      bus.en = 1'b1; bus.req = 4'b0100; bus.ready = 1'b0; bus.last = 1'b0;
      bus.weight = {4'd5, 4'd5, 4'd5, 4'd5};
      tick();
      g = got_vec();
      n_cmp++;
      if (g !== owner_vec(2, 1'b0)) begin
         n_bad++;
         $display("FAIL early_owner2: got %b required %b", g, owner_vec(2, 1'b0));
      end
      bus.req = 4'b1101; bus.ready = 1'b1; bus.last = 1'b1;
      tick();
      g = got_vec();
      n_cmp++;
      if (g !== owner_vec(3, 1'b0)) begin
         n_bad++;
         $display("FAIL early_last: got %b required %b", g, owner_vec(3, 1'b0));
      end
      // owner 2 drops req with ready low
      bus.req = 4'b0000; bus.last = 1'b0; bus.ready = 1'b0;
      do_reset();
      bus.req = 4'b0100;
      tick();
      bus.req = 4'b0001;
      tick();
      g = got_vec();
      n_cmp++;
      if (g !== owner_vec(0, 1'b0)) begin
         n_bad++;
         $display("FAIL early_drop: got %b required %b", g, owner_vec(0, 1'b0));
      end
      // owner drops with nobody else waiting -> IDLE, outputs cleared
      bus.req = 4'b0000;
      tick();
      g = got_vec();
      n_cmp++;
      if (g !== 8'b0) begin
         n_bad++;
         $display("FAIL early_drop_idle: got %b required %b", g, 8'b0);
      end
   endtask

   task automatic test_enable_reset();
      logic [7:0] g;
      bus.req = 4'b0000;
      do_reset();
      bus.en = 1'b1; bus.req = 4'b0001; bus.ready = 1'b1; bus.last = 1'b0;
      bus.weight = {4'd2, 4'd2, 4'd2, 4'd2};
      tick();
      bus.en = 1'b0;
      tick();
      g = got_vec();
      n_cmp++;
      if (g !== owner_vec(0, 1'b0)) begin
         n_bad++;
         $display("FAIL en_low_holds: got %b required %b", g, owner_vec(0, 1'b0));
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         g = got_vec();
         n_cmp++;
         if (g !== 8'b0) begin
            n_bad++;
            $display("FAIL en_low_idle[%0d]: got %b required %b", k, g, 8'b0);
         end
      end
      bus.en = 1'b1;
      tick();
      g = got_vec();
      n_cmp++;
      if (g !== owner_vec(0, 1'b0)) begin
         n_bad++;
         $display("FAIL en_high_regrant: got %b required %b", g, owner_vec(0, 1'b0));
      end
      // reset mid-burst after the pointer has moved to 2
      bus.req = 4'b0000;
      do_reset();
      bus.req = 4'b0110; bus.ready = 1'b1; bus.last = 1'b1;
      bus.weight = {4'd5, 4'd5, 4'd5, 4'd5};
      tick();
      tick();
      bus.last = 1'b0;
      tick();
      g = got_vec();
      n_cmp++;
      if (g !== owner_vec(2, 1'b0)) begin
         n_bad++;
         $display("FAIL rst_pre_owner: got %b required %b", g, owner_vec(2, 1'b0));
      end
      rst = 1'b1;
      tick();
      g = got_vec();
      n_cmp++;
      if (g !== 8'b0) begin
         n_bad++;
         $display("FAIL rst_mid_burst: got %b required %b", g, 8'b0);
      end
      rst = 1'b0;
      tick();
      g = got_vec();
      n_cmp++;
      if (g !== owner_vec(1, 1'b0)) begin
         n_bad++;
         $display("FAIL rst_pointer_zero: got %b required %b", g, owner_vec(1, 1'b0));
      end
   endtask

   task automatic test_timeout();
      logic [7:0] g;
      bus.req = 4'b0000;
      do_reset();
      bus.en = 1'b1; bus.req = 4'b0011; bus.ready = 1'b0; bus.last = 1'b0;
      bus.weight = {4'd2, 4'd2, 4'd2, 4'd2};
`ifdef WRR_BURST_ARB_TIMEOUT_EN
      for (int k = 0; k < 4; k++) begin
         tick();
         g = got_vec();
         n_cmp++;
         if (g !== owner_vec(0, 1'b0)) begin
            n_bad++;
            $display("FAIL timeout_hold[%0d]: got %b required %b", k, g, owner_vec(0, 1'b0));
         end
      end
      tick();
      g = got_vec();
      n_cmp++;
      if (g !== owner_vec(1, 1'b1)) begin
         n_bad++;
         $display("FAIL timeout_release: got %b required %b", g, owner_vec(1, 1'b1));
      end
      tick();
      g = got_vec();
      n_cmp++;
      if (g !== owner_vec(1, 1'b0)) begin
         n_bad++;
         $display("FAIL timeout_pulse_end: got %b required %b", g, owner_vec(1, 1'b0));
      end
`else
      for (int k = 0; k < 25; k++) begin
         tick();
         g = got_vec();
         n_cmp++;
         if (g !== owner_vec(0, 1'b0)) begin
            n_bad++;
            $display("FAIL hold_forever[%0d]: got %b required %b", k, g, owner_vec(0, 1'b0));
         end
      end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.en = 1'b0; bus.req = '0; bus.last = 1'b0; bus.ready = 1'b0; bus.weight = '0;
      test_reset();
      test_quantum_rotation();
      test_weighting();
      test_early_release();
      test_enable_reset();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wrr_burst_arb.md
# wrr_burst_arb

Weighted round-robin burst arbiter sharing one beat-oriented resource (bus port, memory channel) among N requesters. Each grant is held for up to a per-requester quantum of accepted beats, or until the owner sends `last` or drops its request. Priority then rotates to the requester after the owner. It sits between the requester-side round-robin fabric and the shared resource, with fully registered grant outputs.

## Interface
- `N`, 4, number of requesters (2..16)
- `WW`, 4, weight width; quantum range 1..2^WW-1 beats
- `TIMEOUT`, 15, idle-owner cycles before forced release (used only with macro)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  arbitration enable; gates new grants only
- `req`  in  N  request per requester, level, held until served
- `last`  in  1  owner's final beat marker, qualified by `ready`
- `weight`  in  N*WW  quantum per requester, slice i = `weight[i*WW +: WW]`
- `ready`  in  1  resource accepted a beat this cycle
- `grant`  out  N  one-hot grant, registered
- `grant_ID`  out  $clog2(N)  index of owner, registered
- `grant_valid`  out  1  a grant is active
- `timeout`  out  1  one-cycle pulse on forced release (macro only)

## Operation
- FSM states: IDLE, GRANT.
- Reset: state=IDLE, `grant`=0, `grant_ID`=0, `grant_valid`=0, `timeout`=0, pointer=0, beat count=0.
- The pointer selects the highest-priority index. The pick is the first set `req` bit at or above the pointer, wrapping modulo N.
- IDLE: if `en` and `|req`, register the pick into `grant`/`grant_ID`, load quantum = weight[pick], zero the count, and go to GRANT. Otherwise stay.
- A weight of 0 is treated as 1. The weight is sampled only at grant start; later changes have no effect on the current grant.
- GRANT: a beat is counted when `ready` and `req[grant_ID]` are both high.
- Release conditions, any of:
  - `req[grant_ID]`=0
  - a counted beat with `last`=1
  - a counted beat that makes the count equal the quantum
- On release, the pointer becomes (grant_ID+1) mod N.
- On release, if `en` and another request is present (the owner's own request is excluded from this cycle's pick), the next grant is registered in the same edge with no idle bubble. Otherwise go to IDLE with outputs cleared.
- `en`=0 never aborts an active grant; it only blocks the next grant.
- `ready` without a valid owner request is ignored. The count saturates at the quantum and cannot overflow.
- Simultaneous `last` and quantum reached form a single release.
- Reset asserted mid-grant: everything returns to reset values on that edge, and the in-flight burst is abandoned.

## Timing
- Request to grant: 1 cycle. `req` high in cycle t gives `grant` in t+1.
- Release decision is combinational on the current cycle's `req`/`ready`/`last`. The new grant, or cleared grant, is visible the next cycle.
- Back-to-back owners: zero dead cycles.
- The owner is stable for at least 1 cycle per grant. Maximum hold is quantum counted beats (unbounded wall time without the macro).

## Configuration
- `WRR_BURST_ARB_TIMEOUT_EN` defined:
  - A counter tracks GRANT cycles with no counted beat; it resets on every counted beat.
  - When it reaches `TIMEOUT`, the grant is released as a normal release and `timeout` pulses for 1 cycle, aligned with the grant change.
- Undefined: no counter, `timeout` tied 0, and an owner may hold indefinitely while requesting.

## Structure
- Package `wrr_arb_pkg`: state enum (IDLE, GRANT), the weight-slice width localparam helper, and the `N`-to-ID width function.
- Sub-module `rr_pick`: combinational rotate-and-priority-encode, with inputs `req`, `pointer`, `mask` and outputs one-hot, index and `any`. It is instantiated once; the owner exclusion is applied through `mask`.
- Top level holds the FSM, pointer, beat counter, optional timeout counter and output registers.

## Test plan
- Reset: hold `rst` for 2 cycles with `req`=4'b1111 -> `grant`=0, `grant_valid`=0. First grant arrives 1 cycle after `rst` falls, to requester 0.
- Quantum rotation: `req`=4'b1111, weights all 2, `ready`=1, `last`=0 -> grant_ID sequence 0,0,1,1,2,2,3,3,0 with no gaps.
- Weighting: `req`=4'b0011, weight0=3, weight1=1, `ready`=1 -> pattern 0,0,0,1 repeating. Weight 0 on requester 1 behaves as 1.
- Early release: owner 2 asserts `last` on its first accepted beat with quantum 5 -> grant moves to the next requester next cycle. Owner 2 dropping `req` with `ready`=0 also releases it.
- Enable and reset mid-burst: `en`=0 during a grant -> the burst completes, then IDLE persists until `en`=1. `rst` asserted mid-burst -> outputs 0 on the next cycle and the pointer returns to 0.
- Timeout (macro defined, `TIMEOUT`=4): owner holds `req` with `ready`=0 -> release and a `timeout` pulse after 4 cycles. Without the macro the grant is held for more than 20 cycles.
